// File: rtl/fpa_arbiter.sv
// fpa_arbiter: shares one combinational floating-point adder (fpa) among
// N_REQ requesters with valid/ready handshakes and round-robin arbitration.
// Subtraction is done by flipping the sign of operand B before the adder.
//
// Ports:
//   clk, rst      - clock (rising edge), synchronous active-high reset
//   req_valid     - per-requester request strobe
//   req_ready     - one-hot grant (combinational), transfer on valid & ready
//   req_a, req_b  - packed operands, requester i at [i*W +: W]
//   req_sub       - per-requester 1 = A-B, 0 = A+B
//   rsp_valid     - registered result available
//   rsp_ready     - consumer accepts result
//   rsp_result    - registered adder output
//   rsp_id        - index of the requester that produced rsp_result
//   busy          - high whenever the arbiter is not idle

`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

// fpa: combinational IEEE-754 style adder, round-to-nearest-even,
// subnormals supported, NaN/infinity handled as special cases.
//   number_a, number_b - operands
//   number_out         - sum
module fpa #(
    parameter int unsigned EXP_SIZE    = `EXP_SIZE,
    parameter int unsigned MANTIS_SIZE = `MANTIS_SIZE
) (
    input  logic [EXP_SIZE+MANTIS_SIZE:0] number_a,
    input  logic [EXP_SIZE+MANTIS_SIZE:0] number_b,
    output logic [EXP_SIZE+MANTIS_SIZE:0] number_out
);
    localparam int unsigned E  = EXP_SIZE;
    localparam int unsigned M  = MANTIS_SIZE;
    localparam int unsigned W  = 1 + E + M;
    // hidden bit + fraction + guard/round/sticky
    localparam int unsigned XW = M + 4;

    logic          a_sign, b_sign;
    logic [E-1:0]  a_exp, b_exp;
    logic [M-1:0]  a_frac, b_frac;
    logic          a_nan, b_nan, a_inf, b_inf, a_big;
    logic          x_sign, y_sign;
    logic [E-1:0]  x_exp, y_exp, exp_diff;
    logic [XW-1:0] x_man, y_man, y_shift, y_align;
    logic [XW:0]   sum;
    logic [E+1:0]  exp_n, exp_r;
    logic [XW-1:0] norm;
    logic          round_up;
    logic [M+1:0]  man_r;
    logic [M-1:0]  frac_o;

    assign a_sign = number_a[W-1];
    assign b_sign = number_b[W-1];
    assign a_exp  = number_a[W-2 -: E];
    assign b_exp  = number_b[W-2 -: E];
    assign a_frac = number_a[M-1:0];
    assign b_frac = number_b[M-1:0];
    assign a_nan  = (a_exp == '1) && (a_frac != '0);
    assign b_nan  = (b_exp == '1) && (b_frac != '0);
    assign a_inf  = (a_exp == '1) && (a_frac == '0);
    assign b_inf  = (b_exp == '1) && (b_frac == '0);
    assign a_big  = {a_exp, a_frac} >= {b_exp, b_frac};

    // Order by magnitude, align the smaller operand and add/subtract.
    always_comb begin : align_add
        x_sign   = a_big ? a_sign : b_sign;
        y_sign   = a_big ? b_sign : a_sign;
        // subnormals use exponent 1 with a zero hidden bit
        x_exp    = a_big ? ((a_exp == '0) ? E'(1) : a_exp) : ((b_exp == '0) ? E'(1) : b_exp);
        y_exp    = a_big ? ((b_exp == '0) ? E'(1) : b_exp) : ((a_exp == '0) ? E'(1) : a_exp);
        x_man    = a_big ? {|a_exp, a_frac, 3'b000} : {|b_exp, b_frac, 3'b000};
        y_man    = a_big ? {|b_exp, b_frac, 3'b000} : {|a_exp, a_frac, 3'b000};
        exp_diff = x_exp - y_exp;
        y_shift  = y_man >> exp_diff;
        // any bit shifted out folds into the sticky position
        y_align  = y_shift | XW'((y_shift << exp_diff) != y_man);
        if (x_sign == y_sign)
            sum = {1'b0, x_man} + {1'b0, y_align};
        else
            sum = {1'b0, x_man} - {1'b0, y_align};
    end

    // Normalize: one right shift on carry, else left shift down to exp 1.
    always_comb begin : normalize
        exp_n = (E+2)'(x_exp);
        norm  = sum[XW-1:0];
        if (sum[XW]) begin
            norm  = {sum[XW:2], sum[1] | sum[0]};
            exp_n = exp_n + (E+2)'(1);
        end else begin
            for (int i = 0; i < int'(XW); i++) begin
                if (!norm[XW-1] && (exp_n > (E+2)'(1))) begin
                    norm  = norm << 1;
                    exp_n = exp_n - (E+2)'(1);
                end
            end
            if (!norm[XW-1])
                exp_n = '0;
        end
    end

    // Round to nearest even; a subnormal rounding up to the hidden bit
    // becomes the smallest normal.
    always_comb begin : round
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        man_r    = {1'b0, norm[XW-1:3]} + (M+2)'(round_up);
        frac_o   = man_r[M-1:0];
        exp_r    = exp_n;
        if (man_r[M+1]) begin
            frac_o = man_r[M:1];
            exp_r  = exp_n + (E+2)'(1);
        end else if ((exp_n == '0) && man_r[M]) begin
            exp_r = (E+2)'(1);
        end
    end

    always_comb begin : pack_out
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign)))
            number_out = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
        else if (a_inf)
            number_out = number_a;
        else if (b_inf)
            number_out = number_b;
        else if (sum == '0)
            number_out = {a_sign & b_sign, {(W-1){1'b0}}};
        else if (exp_r >= (E+2)'({E{1'b1}}))
            number_out = {x_sign, {E{1'b1}}, {M{1'b0}}};
        else
            number_out = {x_sign, exp_r[E-1:0], frac_o};
    end
endmodule

module fpa_arbiter #(
    parameter int unsigned EXP_SIZE    = `EXP_SIZE,
    parameter int unsigned MANTIS_SIZE = `MANTIS_SIZE,
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ID_W        = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [N_REQ-1:0]                             req_valid,
    output logic [N_REQ-1:0]                             req_ready,
    input  logic [N_REQ*(1+EXP_SIZE+MANTIS_SIZE)-1:0]    req_a,
    input  logic [N_REQ*(1+EXP_SIZE+MANTIS_SIZE)-1:0]    req_b,
    input  logic [N_REQ-1:0]                             req_sub,
    output logic                                         rsp_valid,
    input  logic                                         rsp_ready,
    output logic [EXP_SIZE+MANTIS_SIZE:0]                rsp_result,
    output logic [ID_W-1:0]                              rsp_id,
    output logic                                         busy
);
    localparam int unsigned W = 1 + EXP_SIZE + MANTIS_SIZE;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state, state_next;
    logic [ID_W-1:0] rr_ptr, grant_idx, op_id;
    logic [N_REQ-1:0] grant_oh;
    logic            any_valid, take;
    logic [W-1:0]    sel_a, sel_b, op_a, op_b, fpa_out;

    // Round-robin search: first valid index after rr_ptr, wrapping.
    always_comb begin : rr_search
        int unsigned idx;
        idx       = 0;
        grant_idx = '0;
        any_valid = |req_valid;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            idx = (32'(rr_ptr) + 32'(k)) % N_REQ;
            if (|(req_valid & (N_REQ'(1) << idx)))
                grant_idx = ID_W'(idx);
        end
        grant_oh = N_REQ'(1) << grant_idx;
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    always_comb begin : next_state
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    if (rsp_ready) state_next = any_valid ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant is offered in IDLE, or in DONE once the result is being taken.
    always_comb begin : outputs
        take      = 1'b0;
        req_ready = '0;
        case (state)
            IDLE:    take = any_valid;
            DONE:    take = rsp_ready & any_valid;
            default: take = 1'b0;
        endcase
        take = take & ~rst;
        if (take)
            req_ready = grant_oh;
    end

    assign sel_a = W'(req_a >> (32'(grant_idx) * W));
    assign sel_b = W'(req_b >> (32'(grant_idx) * W));

    // Operand capture, result register and round-robin pointer.
    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= '0;
            rr_ptr     <= ID_W'(N_REQ - 1);
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= '0;
        end else begin
            if (take) begin
                op_a   <= sel_a;
                op_b   <= {sel_b[W-1] ^ (|(req_sub & grant_oh)), sel_b[W-2:0]};
                op_id  <= grant_idx;
                rr_ptr <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_result <= fpa_out;
                rsp_id     <= op_id;
                rsp_valid  <= 1'b1;
            end else if ((state == DONE) && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

    fpa #(
        .EXP_SIZE    (EXP_SIZE),
        .MANTIS_SIZE (MANTIS_SIZE)
    ) u_fpa (
        .number_a   (op_a),
        .number_b   (op_b),
        .number_out (fpa_out)
    );
endmodule
